// File: rtl/alu_muldiv_iterative.sv
// Iterative unsigned multiply/divide unit for one ALU output-mux slot.
// Ports: clk, reset (sync, active-high), start/op/a/b in; ready, busy, done, result out.
module alu_muldiv_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [1:0]       op_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CW-1:0]    cnt_q;
  logic             dz_q;

  logic             accept;
  logic             last;
  logic             is_div;

  logic [WIDTH:0]   msum;
  logic [WIDTH-1:0] mul_hi_n;
  logic [WIDTH-1:0] mul_lo_n;
  logic [WIDTH:0]   rshift;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;
  logic [WIDTH-1:0] sh_n;
  logic [WIDTH-1:0] res_n;

  assign ready  = (state_q != RUN);
  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign accept = ready & start;
  assign last   = (cnt_q == CW'(WIDTH - 1));
  assign is_div = op_q[1];

  // x_q: multiplicand (MUL) or divisor (DIV).
  // sh_q: multiplier shifting out (MUL) or dividend/quotient (DIV).
  always_comb begin
    msum     = {1'b0, hi_q} + (sh_q[0] ? {1'b0, x_q} : '0);
    mul_hi_n = msum[WIDTH:1];
    mul_lo_n = {msum[0], lo_q[WIDTH-1:1]};
    rshift   = {hi_q, sh_q[WIDTH-1]};
    diff     = rshift - {1'b0, x_q};
    rem_n    = diff[WIDTH] ? rshift[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_n    = {sh_q[WIDTH-2:0], ~diff[WIDTH]};
    hi_n     = is_div ? rem_n : mul_hi_n;
    lo_n     = is_div ? lo_q : mul_lo_n;
    sh_n     = is_div ? quo_n : (sh_q >> 1);
    res_n    = '0;
    unique case (op_q)
      2'b00: res_n = mul_lo_n;
      2'b01: res_n = mul_hi_n;
      2'b10: res_n = quo_n;
      2'b11: res_n = rem_n;
      default: res_n = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A zero divisor still spends one RUN cycle so its done lands
  // one cycle after accept, then exits without iterating.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE,
      DONE:    state_d = accept ? RUN : IDLE;
      RUN:     if (dz_q || last) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= '0;
      x_q    <= '0;
      sh_q   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt_q  <= '0;
      dz_q   <= 1'b0;
      result <= '0;
    end else if (accept) begin
      op_q  <= op;
      x_q   <= op[1] ? b : a;
      sh_q  <= op[1] ? a : b;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
      dz_q  <= op[1] & (b == '0);
    end else if (state_q == RUN) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      sh_q  <= sh_n;
      cnt_q <= cnt_q + 1'b1;
      if (dz_q)
        result <= op_q[0] ? sh_q : '1;
      else if (last)
        result <= res_n;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_iterative.sv
// Self-checking bench for alu_muldiv_iterative.
// Directed and random ops scored against a plain-arithmetic model.
module tb_alu_muldiv_iterative;

  logic        clk = 0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        ready, busy, done;
  logic [31:0] result;

  int passed = 0;
  int total  = 0;

  alu_muldiv_iterative #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .ready(ready), .busy(busy),
    .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(
    input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    p = {32'd0, x} * {32'd0, y};
    case (o)
      2'b00: return p[31:0];
      2'b01: return p[63:32];
      2'b10: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input string tag);
    logic [31:0] exp;
    bit dz;
    int lat;
    int want;
    exp  = model(o, x, y);
    dz   = o[1] && (y == 0);
    want = dz ? 1 : 32;
    start = 1; op = o; a = x; b = y;
    total++;
    if (ready !== 1'b1) $display("FAIL %s ready_pre got=%b want=1", tag, ready);
    else passed++;
    tick();
    start = 0;
    if (!dz) begin
      total++;
      if (busy !== 1'b1 || ready !== 1'b0)
        $display("FAIL %s busy_post got busy=%b ready=%b want 1/0", tag, busy, ready);
      else passed++;
    end
    lat = 0;
    do begin
      tick();
      lat++;
    end while (done !== 1'b1 && lat < 40);
    total++;
    if (lat !== want) $display("FAIL %s latency got=%0d want=%0d", tag, lat, want);
    else passed++;
    total++;
    if (result !== exp) $display("FAIL %s result got=%h want=%h", tag, result, exp);
    else passed++;
    tick();
    total++;
    if (done !== 1'b0 || result !== exp)
      $display("FAIL %s hold got done=%b res=%h want 0/%h", tag, done, result, exp);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1; start = 0; op = 0; a = 0; b = 0;
    repeat (3) tick();
    total++;
    if ({ready, busy, done} !== 3'b100 || result !== 32'd0)
      $display("FAIL reset_state got r=%b b=%b d=%b res=%h want 1/0/0/0",
               ready, busy, done, result);
    else passed++;
    start = 1; a = 3; b = 4;
    tick();
    total++;
    if (busy !== 1'b0) $display("FAIL reset_prio busy got=%b want=0", busy);
    else passed++;
    reset = 0; start = 0;
    tick();
  endtask

  task automatic test_directed();
    run_op(2'b00, 7, 6, "mul_7x6");
    run_op(2'b01, 7, 6, "mulhu_7x6");
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
    run_op(2'b10, 100, 7, "divu_100_7");
    run_op(2'b11, 100, 7, "remu_100_7");
    run_op(2'b10, 5, 9, "divu_5_9");
    run_op(2'b11, 5, 9, "remu_5_9");
    run_op(2'b10, 32'hFFFF_FFFF, 1, "divu_max_1");
  endtask

  task automatic test_div_zero();
    run_op(2'b10, 1234, 0, "divu_zero");
    run_op(2'b11, 1234, 0, "remu_zero");
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = 32'($urandom_range(0, 3));
        1: y = $urandom >> $urandom_range(0, 31);
        default: y = $urandom;
      endcase
      run_op(o, x, y, $sformatf("rand%0d_op%0d", i, o));
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    start = 1; op = 2'b00; a = 1000; b = 77;
    tick();
    start = 0;
    repeat (10) tick();
    start = 1; op = 2'b10; a = 9; b = 3;
    tick();
    start = 0;
    total++;
    if (busy !== 1'b1) $display("FAIL ignore_busy got=%b want=1", busy);
    else passed++;
    lat = 11;
    do begin
      tick();
      lat++;
    end while (done !== 1'b1 && lat < 40);
    total++;
    if (lat !== 32) $display("FAIL ignore_latency got=%0d want=32", lat);
    else passed++;
    total++;
    if (result !== 32'd77000) $display("FAIL ignore_result got=%h want=%h", result, 32'd77000);
    else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    start = 1; op = 2'b01; a = 32'h8000_0000; b = 32'h0000_0010;
    tick();
    start = 0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (done !== 1'b1 && lat < 40);
    total++;
    if (result !== 32'h8) $display("FAIL b2b_first got=%h want=8", result);
    else passed++;
    start = 1; op = 2'b11; a = 1000; b = 33;
    tick();
    start = 0;
    total++;
    if (done !== 1'b0 || busy !== 1'b1)
      $display("FAIL b2b_accept got done=%b busy=%b want 0/1", done, busy);
    else passed++;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (done !== 1'b1 && lat < 40);
    total++;
    if (lat !== 32) $display("FAIL b2b_latency got=%0d want=32", lat);
    else passed++;
    total++;
    if (result !== 32'd10) $display("FAIL b2b_result got=%h want=a", result);
    else passed++;
    tick();
  endtask

  task automatic test_reset_abort();
    bit seen;
    start = 1; op = 2'b00; a = 11; b = 13;
    tick();
    start = 0;
    repeat (15) tick();
    reset = 1;
    tick();
    reset = 0;
    total++;
    if ({ready, busy, done} !== 3'b100 || result !== 32'd0)
      $display("FAIL abort_state got r=%b b=%b d=%b res=%h want 1/0/0/0",
               ready, busy, done, result);
    else passed++;
    seen = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) seen = 1;
    end
    total++;
    if (seen) $display("FAIL abort_no_done got=1 want=0");
    else passed++;
    run_op(2'b00, 3, 5, "mul_after_abort");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
